// File: rtl/wb_arb2.sv
// Two-master Wishbone arbiter sharing one slave: round-robin grant held for
// the whole CYC, with a per-transfer ACK timeout that errors the owner.
module wb_arb2 #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 64
) (
   input  logic          CLK_I,
   input  logic          RST_I,

   input  logic          M0_CYC_I,
   input  logic          M0_STB_I,
   input  logic          M0_WE_I,
   input  logic [AW-1:0] M0_ADR_I,
   input  logic [DW-1:0] M0_DAT_I,
   output logic [DW-1:0] M0_DAT_O,
   output logic          M0_ACK_O,
   output logic          M0_ERR_O,

   input  logic          M1_CYC_I,
   input  logic          M1_STB_I,
   input  logic          M1_WE_I,
   input  logic [AW-1:0] M1_ADR_I,
   input  logic [DW-1:0] M1_DAT_I,
   output logic [DW-1:0] M1_DAT_O,
   output logic          M1_ACK_O,
   output logic          M1_ERR_O,

   output logic          S_CYC_O,
   output logic          S_STB_O,
   output logic          S_WE_O,
   output logic [AW-1:0] S_ADR_O,
   output logic [DW-1:0] S_DAT_O,
   input  logic [DW-1:0] S_DAT_I,
   input  logic          S_ACK_I,

   output logic [1:0]    GNT_O
);

   localparam logic [7:0] TLIM = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, OWN, HOLD} state_t;

   state_t        state_reg;
   logic          owner_reg;
   logic          last_reg;
   logic [7:0]    tcnt_reg;
   logic [1:0]    gnt_reg;

   logic [1:0]    cyc;
   logic [1:0]    stb;
   logic [1:0]    we;
   logic [AW-1:0] adr [2];
   logic [DW-1:0] dat [2];
   logic [1:0]    ack;
   logic [1:0]    err;
   logic [DW-1:0] rdat [2];

   logic          own_cyc;
   logic          own_stb;
   logic          active;
   logic          timeout_hit;
   logic          pick;

   assign cyc    = {M1_CYC_I, M0_CYC_I};
   assign stb    = {M1_STB_I, M0_STB_I};
   assign we     = {M1_WE_I,  M0_WE_I};
   assign adr[0] = M0_ADR_I;
   assign adr[1] = M1_ADR_I;
   assign dat[0] = M0_DAT_I;
   assign dat[1] = M1_DAT_I;

   assign own_cyc = cyc[owner_reg];
   assign own_stb = stb[owner_reg];

   // Reset gates every combinational path so an aborted transfer never errors.
   assign active      = (state_reg == OWN) && !RST_I;
   assign timeout_hit = active && own_cyc && own_stb && !S_ACK_I && (tcnt_reg == TLIM);

   // On a tie the master that did not own the slave last time wins.
   assign pick = (cyc == 2'b11) ? ~last_reg : cyc[1];

   assign S_CYC_O = active && own_cyc;
   assign S_STB_O = active && own_stb;
   assign S_WE_O  = active && we[owner_reg];
   assign S_ADR_O = active ? adr[owner_reg] : '0;
   assign S_DAT_O = active ? dat[owner_reg] : '0;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_master
         assign ack[gi]  = active && (owner_reg == 1'(gi)) && S_ACK_I;
         assign err[gi]  = timeout_hit && (owner_reg == 1'(gi));
         assign rdat[gi] = S_DAT_I;
      end
   endgenerate

   assign M0_ACK_O = ack[0];
   assign M1_ACK_O = ack[1];
   assign M0_ERR_O = err[0];
   assign M1_ERR_O = err[1];
   assign M0_DAT_O = rdat[0];
   assign M1_DAT_O = rdat[1];
   assign GNT_O    = gnt_reg;

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state_reg <= IDLE;
         owner_reg <= 1'b0;
         last_reg  <= 1'b1;
         tcnt_reg  <= 8'd0;
         gnt_reg   <= 2'b00;
      end else begin
         case (state_reg)
            IDLE: begin
               tcnt_reg <= 8'd0;
               if (|cyc) begin
                  state_reg <= OWN;
                  owner_reg <= pick;
                  gnt_reg   <= pick ? 2'b10 : 2'b01;
               end
            end
            OWN: begin
               if (!own_cyc) begin
                  state_reg <= IDLE;
                  last_reg  <= owner_reg;
                  gnt_reg   <= 2'b00;
                  tcnt_reg  <= 8'd0;
               end else if (timeout_hit) begin
                  state_reg <= HOLD;
                  tcnt_reg  <= 8'd0;
               end else if (S_ACK_I || !own_stb) begin
                  tcnt_reg <= 8'd0;
               end else begin
                  tcnt_reg <= tcnt_reg + 8'd1;
               end
            end
            HOLD: begin
               // Slave is parked until the errored master gives up its cycle.
               if (!own_cyc) begin
                  state_reg <= IDLE;
                  last_reg  <= owner_reg;
                  gnt_reg   <= 2'b00;
               end
            end
            default: begin
               state_reg <= IDLE;
               gnt_reg   <= 2'b00;
               tcnt_reg  <= 8'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_arb2.sv
// Self-checking bench for wb_arb2: directed scenarios plus randomized
// back-to-back contention checked against a transaction-level model.
module tb_wb_arb2;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   logic          CLK_I = 1'b0;
   logic          RST_I;
   logic          M0_CYC_I, M0_STB_I, M0_WE_I;
   logic [AW-1:0] M0_ADR_I;
   logic [DW-1:0] M0_DAT_I;
   logic [DW-1:0] M0_DAT_O;
   logic          M0_ACK_O, M0_ERR_O;
   logic          M1_CYC_I, M1_STB_I, M1_WE_I;
   logic [AW-1:0] M1_ADR_I;
   logic [DW-1:0] M1_DAT_I;
   logic [DW-1:0] M1_DAT_O;
   logic          M1_ACK_O, M1_ERR_O;
   logic          S_CYC_O, S_STB_O, S_WE_O;
   logic [AW-1:0] S_ADR_O;
   logic [DW-1:0] S_DAT_O;
   logic [DW-1:0] S_DAT_I;
   logic          S_ACK_I;
   logic [1:0]    GNT_O;

   int checks = 0;
   int errors = 0;

   always #5 CLK_I = ~CLK_I;

   wb_arb2 #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
      .CLK_I(CLK_I), .RST_I(RST_I),
      .M0_CYC_I(M0_CYC_I), .M0_STB_I(M0_STB_I), .M0_WE_I(M0_WE_I),
      .M0_ADR_I(M0_ADR_I), .M0_DAT_I(M0_DAT_I), .M0_DAT_O(M0_DAT_O),
      .M0_ACK_O(M0_ACK_O), .M0_ERR_O(M0_ERR_O),
      .M1_CYC_I(M1_CYC_I), .M1_STB_I(M1_STB_I), .M1_WE_I(M1_WE_I),
      .M1_ADR_I(M1_ADR_I), .M1_DAT_I(M1_DAT_I), .M1_DAT_O(M1_DAT_O),
      .M1_ACK_O(M1_ACK_O), .M1_ERR_O(M1_ERR_O),
      .S_CYC_O(S_CYC_O), .S_STB_O(S_STB_O), .S_WE_O(S_WE_O),
      .S_ADR_O(S_ADR_O), .S_DAT_O(S_DAT_O), .S_DAT_I(S_DAT_I),
      .S_ACK_I(S_ACK_I), .GNT_O(GNT_O)
   );

   task automatic next_cycle();
      @(posedge CLK_I);
      #1;
   endtask

   task automatic idle_inputs();
      M0_CYC_I = 0; M0_STB_I = 0; M0_WE_I = 0; M0_ADR_I = '0; M0_DAT_I = '0;
      M1_CYC_I = 0; M1_STB_I = 0; M1_WE_I = 0; M1_ADR_I = '0; M1_DAT_I = '0;
      S_ACK_I  = 0; S_DAT_I  = $urandom;
   endtask

   task automatic do_reset();
      idle_inputs();
      RST_I = 1;
      next_cycle();
      RST_I = 0;
   endtask

   task automatic test_reset();
      RST_I = 1;
      M0_CYC_I = 1; M0_STB_I = 1; M0_WE_I = 1; M0_ADR_I = $urandom; M0_DAT_I = $urandom;
      M1_CYC_I = 1; M1_STB_I = 1; M1_WE_I = 1; M1_ADR_I = $urandom; M1_DAT_I = $urandom;
      S_ACK_I = 1;
      next_cycle();
      #1;
      checks++;
      if ({S_CYC_O, S_STB_O, S_WE_O, M0_ACK_O, M1_ACK_O, M0_ERR_O, M1_ERR_O} !== 7'b0) begin
         errors++;
         $display("FAIL reset_ctl got %b exp 0000000", {S_CYC_O, S_STB_O, S_WE_O, M0_ACK_O, M1_ACK_O, M0_ERR_O, M1_ERR_O});
      end
      checks++;
      if (S_ADR_O !== '0 || S_DAT_O !== '0) begin
         errors++;
         $display("FAIL reset_bus got adr %h dat %h exp 0", S_ADR_O, S_DAT_O);
      end
      checks++;
      if (GNT_O !== 2'b00) begin
         errors++;
         $display("FAIL reset_gnt got %b exp 00", GNT_O);
      end
      idle_inputs();
      RST_I = 0;
      next_cycle();
      #1;
      checks++;
      if (GNT_O !== 2'b00) begin
         errors++;
         $display("FAIL idle_gnt got %b exp 00", GNT_O);
      end
   endtask

   task automatic test_single_write();
      do_reset();
      M0_CYC_I = 1; M0_STB_I = 1; M0_WE_I = 1; M0_ADR_I = '0; M0_DAT_I = 32'h30201;
      #1;
      checks++;
      if (GNT_O !== 2'b00 || S_CYC_O !== 1'b0) begin
         errors++;
         $display("FAIL sw_latency got gnt %b cyc %b exp 00 0", GNT_O, S_CYC_O);
      end
      next_cycle();
      #1;
      checks++;
      if (GNT_O !== 2'b01) begin
         errors++;
         $display("FAIL sw_gnt got %b exp 01", GNT_O);
      end
      checks++;
      if (S_DAT_O !== 32'h30201 || S_ADR_O !== '0 || {S_CYC_O, S_STB_O, S_WE_O} !== 3'b111) begin
         errors++;
         $display("FAIL sw_mirror got dat %h adr %h ctl %b exp 30201 0 111", S_DAT_O, S_ADR_O, {S_CYC_O, S_STB_O, S_WE_O});
      end
      for (int i = 0; i < 2; i++) begin
         next_cycle();
         #1;
         checks++;
         if (M0_ACK_O !== 1'b0) begin
            errors++;
            $display("FAIL sw_early_ack got %b exp 0", M0_ACK_O);
         end
      end
      next_cycle();
      S_ACK_I = 1;
      #1;
      checks++;
      if ({M1_ACK_O, M0_ACK_O} !== 2'b01) begin
         errors++;
         $display("FAIL sw_ack got %b exp 01", {M1_ACK_O, M0_ACK_O});
      end
      next_cycle();
      S_ACK_I = 0; M0_CYC_I = 0; M0_STB_I = 0;
      #1;
      next_cycle();
      #1;
      checks++;
      if (GNT_O !== 2'b00 || S_CYC_O !== 1'b0) begin
         errors++;
         $display("FAIL sw_release got gnt %b cyc %b exp 00 0", GNT_O, S_CYC_O);
      end
   endtask

   task automatic test_simultaneous();
      logic [AW-1:0] a0, a1;
      a0 = $urandom; a1 = $urandom;
      do_reset();
      M0_CYC_I = 1; M0_STB_I = 1; M0_ADR_I = a0;
      M1_CYC_I = 1; M1_STB_I = 1; M1_ADR_I = a1;
      next_cycle();
      #1;
      checks++;
      if (GNT_O !== 2'b01 || S_ADR_O !== a0) begin
         errors++;
         $display("FAIL sim_first got gnt %b adr %h exp 01 %h", GNT_O, S_ADR_O, a0);
      end
      S_ACK_I = 1;
      #1;
      checks++;
      if ({M1_ACK_O, M0_ACK_O} !== 2'b01) begin
         errors++;
         $display("FAIL sim_ack got %b exp 01", {M1_ACK_O, M0_ACK_O});
      end
      next_cycle();
      S_ACK_I = 0; M0_CYC_I = 0; M0_STB_I = 0;
      next_cycle();
      #1;
      checks++;
      if (GNT_O !== 2'b00) begin
         errors++;
         $display("FAIL sim_bubble got %b exp 00", GNT_O);
      end
      next_cycle();
      #1;
      checks++;
      if (GNT_O !== 2'b10 || S_ADR_O !== a1) begin
         errors++;
         $display("FAIL sim_second got gnt %b adr %h exp 10 %h", GNT_O, S_ADR_O, a1);
      end
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] q_adr [2][4];
      logic [DW-1:0] q_dat [2][4];
      logic          q_we  [2][4];
      logic          m_cyc [2];
      logic          m_we  [2];
      logic [AW-1:0] m_adr [2];
      logic [DW-1:0] m_dat [2];
      logic          ack_seen [2];
      int            done [2];
      int            grants, bad_m1, err_seen, wait_cnt, delay, exp_owner;
      logic [1:0]    prev_gnt, exp_gnt;
      logic [DW-1:0] rd, got_rd;
      do_reset();
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < 4; i++) begin
            q_adr[m][i] = $urandom;
            q_dat[m][i] = $urandom;
            q_we[m][i]  = 1'($urandom_range(1, 0));
         end
         m_cyc[m] = 0; m_we[m] = 0; m_adr[m] = '0; m_dat[m] = '0;
         ack_seen[m] = 0; done[m] = 0;
      end
      grants = 0; bad_m1 = 0; err_seen = 0; wait_cnt = 0; exp_owner = 0;
      delay = $urandom_range(3, 0); prev_gnt = 2'b00; rd = '0;
      for (int n = 0; n < 300 && !(done[0] == 4 && done[1] == 4); n++) begin
         S_ACK_I = 0;
         for (int m = 0; m < 2; m++) begin
            if (ack_seen[m]) begin
               done[m]++;
               m_cyc[m] = 0;
               ack_seen[m] = 0;
            end else if (!m_cyc[m] && done[m] < 4) begin
               m_cyc[m] = 1;
               m_we[m]  = q_we[m][done[m]];
               m_adr[m] = q_adr[m][done[m]];
               m_dat[m] = q_dat[m][done[m]];
            end
         end
         M0_CYC_I = m_cyc[0]; M0_STB_I = m_cyc[0]; M0_WE_I = m_we[0]; M0_ADR_I = m_adr[0]; M0_DAT_I = m_dat[0];
         M1_CYC_I = m_cyc[1]; M1_STB_I = m_cyc[1]; M1_WE_I = m_we[1]; M1_ADR_I = m_adr[1]; M1_DAT_I = m_dat[1];
         #1;
         if (GNT_O != 2'b00 && GNT_O != prev_gnt) begin
            exp_owner = grants % 2;
            exp_gnt = (exp_owner == 1) ? 2'b10 : 2'b01;
            checks++;
            if (GNT_O !== exp_gnt) begin
               errors++;
               $display("FAIL b2b_grant%0d got %b exp %b", grants, GNT_O, exp_gnt);
            end
            grants++;
         end
         prev_gnt = GNT_O;
         if (S_CYC_O && S_STB_O) begin
            if (wait_cnt == delay) begin
               S_ACK_I = 1;
               rd = $urandom;
               S_DAT_I = rd;
               wait_cnt = 0;
               delay = $urandom_range(3, 0);
            end else begin
               wait_cnt++;
            end
         end
         #1;
         if (GNT_O == 2'b01 && M1_ACK_O) bad_m1++;
         if (M0_ERR_O || M1_ERR_O) err_seen++;
         if (S_ACK_I) begin
            exp_gnt = (exp_owner == 1) ? 2'b10 : 2'b01;
            got_rd = (exp_owner == 1) ? M1_DAT_O : M0_DAT_O;
            $display("b2b xfer m%0d #%0d adr %h we %b wdat %h rdat %h", exp_owner, done[exp_owner],
                     S_ADR_O, S_WE_O, S_DAT_O, got_rd);
            checks++;
            if ({M1_ACK_O, M0_ACK_O} !== exp_gnt) begin
               errors++;
               $display("FAIL b2b_ack got %b exp %b", {M1_ACK_O, M0_ACK_O}, exp_gnt);
            end
            checks++;
            if (S_ADR_O !== q_adr[exp_owner][done[exp_owner]] || S_WE_O !== q_we[exp_owner][done[exp_owner]] ||
                S_DAT_O !== q_dat[exp_owner][done[exp_owner]]) begin
               errors++;
               $display("FAIL b2b_xfer got adr %h we %b dat %h exp %h %b %h", S_ADR_O, S_WE_O, S_DAT_O,
                        q_adr[exp_owner][done[exp_owner]], q_we[exp_owner][done[exp_owner]],
                        q_dat[exp_owner][done[exp_owner]]);
            end
            checks++;
            if (got_rd !== rd) begin
               errors++;
               $display("FAIL b2b_rdata got %h exp %h", got_rd, rd);
            end
            ack_seen[0] = M0_ACK_O;
            ack_seen[1] = M1_ACK_O;
         end
         next_cycle();
      end
      checks++;
      if (done[0] !== 4 || done[1] !== 4 || grants !== 8) begin
         errors++;
         $display("FAIL b2b_complete got m0 %0d m1 %0d grants %0d exp 4 4 8", done[0], done[1], grants);
      end
      checks++;
      if (bad_m1 !== 0 || err_seen !== 0) begin
         errors++;
         $display("FAIL b2b_stray got m1ack %0d err %0d exp 0 0", bad_m1, err_seen);
      end
      idle_inputs();
      next_cycle();
   endtask

   task automatic test_timeout();
      int early;
      early = 0;
      do_reset();
      M0_CYC_I = 1; M0_STB_I = 1; M0_WE_I = 1; M0_ADR_I = $urandom;
      for (int k = 1; k <= TO; k++) begin
         next_cycle();
         #1;
         if (k < TO && M0_ERR_O) early++;
      end
      checks++;
      if ({M1_ERR_O, M0_ERR_O, M0_ACK_O} !== 3'b010 || early !== 0) begin
         errors++;
         $display("FAIL to_err got err %b%b ack %b early %0d exp 01 0 0", M1_ERR_O, M0_ERR_O, M0_ACK_O, early);
      end
      next_cycle();
      S_ACK_I = 1;
      #1;
      checks++;
      if ({S_CYC_O, S_STB_O, M0_ACK_O, M0_ERR_O} !== 4'b0000) begin
         errors++;
         $display("FAIL to_hold got %b exp 0000", {S_CYC_O, S_STB_O, M0_ACK_O, M0_ERR_O});
      end
      next_cycle();
      S_ACK_I = 0; M0_CYC_I = 0; M0_STB_I = 0;
      next_cycle();
      #1;
      checks++;
      if (GNT_O !== 2'b00) begin
         errors++;
         $display("FAIL to_release got %b exp 00", GNT_O);
      end
   endtask

   task automatic test_ack_at_limit();
      int early;
      early = 0;
      do_reset();
      M0_CYC_I = 1; M0_STB_I = 1; M0_ADR_I = $urandom;
      for (int k = 1; k < TO; k++) begin
         next_cycle();
      end
      next_cycle();
      S_ACK_I = 1;
      #1;
      checks++;
      if ({M0_ACK_O, M0_ERR_O} !== 2'b10) begin
         errors++;
         $display("FAIL lim_ack got ack %b err %b exp 1 0", M0_ACK_O, M0_ERR_O);
      end
      next_cycle();
      S_ACK_I = 0;
      #1;
      checks++;
      if (S_CYC_O !== 1'b1 || GNT_O !== 2'b01) begin
         errors++;
         $display("FAIL lim_own got cyc %b gnt %b exp 1 01", S_CYC_O, GNT_O);
      end
      if (M0_ERR_O) early++;
      for (int k = 2; k <= TO; k++) begin
         next_cycle();
         #1;
         if (k < TO && M0_ERR_O) early++;
      end
      checks++;
      if (M0_ERR_O !== 1'b1 || early !== 0) begin
         errors++;
         $display("FAIL lim_restart got err %b early %0d exp 1 0", M0_ERR_O, early);
      end
      do_reset();
   endtask

   task automatic test_reset_mid();
      do_reset();
      M1_CYC_I = 1; M1_STB_I = 1; M1_ADR_I = $urandom;
      next_cycle();
      #1;
      checks++;
      if (GNT_O !== 2'b10) begin
         errors++;
         $display("FAIL rm_gnt got %b exp 10", GNT_O);
      end
      for (int k = 2; k < TO; k++) begin
         next_cycle();
      end
      next_cycle();
      RST_I = 1;
      #1;
      checks++;
      if ({M1_ERR_O, M1_ACK_O, S_CYC_O, S_STB_O} !== 4'b0000) begin
         errors++;
         $display("FAIL rm_during got %b exp 0000", {M1_ERR_O, M1_ACK_O, S_CYC_O, S_STB_O});
      end
      next_cycle();
      RST_I = 0;
      M0_CYC_I = 1; M0_STB_I = 1; M0_ADR_I = $urandom;
      #1;
      checks++;
      if (GNT_O !== 2'b00 || {S_CYC_O, S_STB_O, S_WE_O} !== 3'b000 || S_ADR_O !== '0) begin
         errors++;
         $display("FAIL rm_after got gnt %b ctl %b adr %h exp 00 000 0", GNT_O, {S_CYC_O, S_STB_O, S_WE_O}, S_ADR_O);
      end
      next_cycle();
      #1;
      checks++;
      if (GNT_O !== 2'b01) begin
         errors++;
         $display("FAIL rm_tie got %b exp 01", GNT_O);
      end
      do_reset();
   endtask

   initial begin
      RST_I = 1;
      idle_inputs();
      next_cycle();
      test_reset();
      test_single_write();
      test_simultaneous();
      test_back_to_back();
      test_timeout();
      test_ack_at_limit();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/wb_arb2.md
WB_ARB2 -- requirements
Module: wb_arb2

Interface
REQ-001 The block SHALL have parameter AW, default 32, meaning address width.
REQ-002 The block SHALL have parameter DW, default 32, meaning data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 64, meaning cycles without ACK before abort (legal range 2..255).
REQ-004 The block SHALL have port CLK_I  input  1  the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port RST_I  input  1  reset, synchronous and active-high.
REQ-006 The block SHALL have ports Mx_CYC_I, Mx_STB_I, Mx_WE_I (x=0,1)  input  1 each  master x Wishbone cycle, strobe and write-enable.
REQ-007 The block SHALL have port Mx_ADR_I  input  AW  master x address.
REQ-008 The block SHALL have port Mx_DAT_I  input  DW  master x write data.
REQ-009 The block SHALL have port Mx_DAT_O  output  DW  master x read data.
REQ-010 The block SHALL have ports Mx_ACK_O, Mx_ERR_O  output  1 each  master x acknowledge and error.
REQ-011 The block SHALL have ports S_CYC_O, S_STB_O, S_WE_O  output  1 each  shared slave controls.
REQ-012 The block SHALL have ports S_ADR_O  output  AW and S_DAT_O  output  DW  shared slave address and write data.
REQ-013 The block SHALL have ports S_DAT_I  input  DW and S_ACK_I  input  1  slave read data and acknowledge.
REQ-014 The block SHALL have port GNT_O  output  2  one-hot registered grant (bit x = master x owns the slave).

Function
REQ-015 The FSM SHALL have states IDLE, OWN and HOLD, plus a register last (the last owner) and a counter tcnt of 8 bits.
REQ-016 In IDLE with exactly one Mx_CYC_I high, the FSM SHALL grant that master at the next edge and enter OWN (one-cycle arbitration latency).
REQ-017 In IDLE with both Mx_CYC_I high, the FSM SHALL grant the master not equal to last (round robin).
REQ-018 In OWN, S_CYC/STB/WE/ADR/DAT_O SHALL combinationally mirror the owner's inputs.
REQ-019 In OWN, S_ACK_I SHALL drive the owner's ACK_O combinationally, and S_DAT_I SHALL drive both Mx_DAT_O.
REQ-020 The non-owner's ACK_O and ERR_O SHALL be 0 at all times.
REQ-021 The grant SHALL be held for as long as the owner's CYC_I stays high, across any number of STB transfers; the other master's requests SHALL be ignored meanwhile.
REQ-022 tcnt SHALL clear on S_ACK_I or when the owner's STB_I is low, and SHALL increment each OWN cycle with STB high and no ACK.
REQ-023 When tcnt==TIMEOUT-1 and S_ACK_I is low, the block SHALL pulse the owner's ERR_O for that one cycle and SHALL enter HOLD.
REQ-024 If S_ACK_I and the timeout occur in the same cycle, ACK SHALL win: no ERR and no HOLD.
REQ-025 In HOLD, all S_* outputs SHALL be 0 and S_ACK_I SHALL be ignored; the FSM SHALL return to IDLE when the owner's CYC_I is low.
REQ-026 When the owner drops CYC_I in OWN, the FSM SHALL enter IDLE at the next edge and update last to the owner; a pending request from the other master SHALL be granted one cycle later (one-cycle bubble).
REQ-027 In IDLE, S_* outputs SHALL be 0, S_ACK_I SHALL be ignored and GNT_O SHALL be 00.

Reset
REQ-028 While RST_I is high at a clock edge, the FSM SHALL enter IDLE, with last=1 (so M0 wins the first tie), tcnt=0 and GNT_O=00.
REQ-029 While RST_I is high, all S_* outputs SHALL be 0 and all Mx_ACK_O/Mx_ERR_O SHALL be 0.
REQ-030 A reset asserted mid-transfer SHALL abort the transfer without an ERR pulse.

Verification
REQ-031 Single write: M0 writes ADR=0, DAT=32'h30201, and the slave ACKs 3 cycles later -> GNT_O=01 one cycle after CYC, S_DAT_O=32'h30201, M0_ACK_O one cycle, IDLE after CYC drops.
REQ-032 Simultaneous requests after reset: M0 and M1 both raise CYC -> M0 is granted first; after M0 releases, M1 is granted two cycles after M0's CYC falls.
REQ-033 Back-to-back contention of 4 transfers each -> grants alternate 0,1,0,1,...; no transfer is lost; M1_ACK_O never asserts while GNT_O=01.
REQ-034 Timeout: TIMEOUT=8, slave never ACKs -> M0_ERR_O pulses on the 8th STB cycle, S_CYC_O=0 in HOLD, IDLE after M0 drops CYC.
REQ-035 ACK on cycle TIMEOUT-1 -> ACK is delivered, no ERR, state stays OWN.
REQ-036 RST_I=1 for one cycle during M1's wait for ACK -> GNT_O=00 and all S_*=0 next cycle; the next tie is granted to M0.
